// File: rtl/ifmp_bus_arbiter.sv
// Round-robin arbiter that shares one sig1/sig2 bus among NUM_REQ requesters.
// Latches the winner's word, holds it until acknowledge or timeout.
module ifmp_bus_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int BUS_WIDTH = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*BUS_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [NUM_REQ-1:0]           done,
    output logic [NUM_REQ-1:0]           err,
    output logic [BUS_WIDTH-1:0]         sig1,
    output logic                         sig1_valid,
    input  logic                         sig2,
    output logic                         busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {IDLE, XFER} state_t;

    state_t                 state_q;
    logic [NUM_REQ-1:0]     gnt_q;
    logic [NUM_REQ-1:0]     done_q;
    logic [NUM_REQ-1:0]     err_q;
    logic [BUS_WIDTH-1:0]   sig1_q;
    logic                   valid_q;
    logic                   busy_q;
    logic [CW-1:0]          cnt_q;
    logic [IW-1:0]          last_q;

    logic [IW-1:0]          win_d;
    logic [BUS_WIDTH-1:0]   words [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign words[g] = req_data[g*BUS_WIDTH +: BUS_WIDTH];
    end

    // Winner: first set request scanning upward from the slot after the last winner.
    always_comb begin
        logic        found;
        logic [IW-1:0] idx_w;
        int          idx;
        found = 1'b0;
        win_d = '0;
        idx   = 0;
        idx_w = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(last_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            idx_w = IW'(idx);
            if (!found && req[idx_w]) begin
                found = 1'b1;
                win_d = idx_w;
            end
        end
    end

    // Transfer FSM with all bus-facing outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            sig1_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            last_q  <= IW'(NUM_REQ - 1);
        end else begin
            done_q <= '0;
            err_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        state_q <= XFER;
                        gnt_q   <= NUM_REQ'(1) << win_d;
                        sig1_q  <= words[win_d];
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        last_q  <= win_d;
                    end
                end
                XFER: begin
                    if (sig2 || cnt_q == CNT_LAST) begin
                        if (sig2) done_q <= gnt_q;
                        else      err_q  <= gnt_q;
                        state_q <= IDLE;
                        gnt_q   <= '0;
                        sig1_q  <= '0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt        = gnt_q;
    assign done       = done_q;
    assign err        = err_q;
    assign sig1       = sig1_q;
    assign sig1_valid = valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ifmp_bus_arbiter.sv
// Directed bench for ifmp_bus_arbiter: vector table plus
// hand-written timeout, late-ack and mid-transfer reset sequences.
module tb_ifmp_bus_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 16;

    localparam logic [W-1:0] D0 = 32'h1111_0000;
    localparam logic [W-1:0] D1 = 32'h2222_0001;
    localparam logic [W-1:0] D2 = 32'hDEAD_BEEF;
    localparam logic [W-1:0] D3 = 32'h4444_0003;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   gnt, done, err;
    logic [W-1:0]   sig1;
    logic           sig1_valid, sig2, busy;

    int checks = 0;
    int passed = 0;

    ifmp_bus_arbiter #(.NUM_REQ(N), .BUS_WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
        .gnt(gnt), .done(done), .err(err), .sig1(sig1),
        .sig1_valid(sig1_valid), .sig2(sig2), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst_n;
        logic [N-1:0] req;
        logic         sig2;
        logic [N-1:0] gnt;
        logic [N-1:0] done;
        logic [N-1:0] err;
        logic         valid;
        logic [W-1:0] sig1;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(input logic r, input logic [N-1:0] rq,
                                input logic s2, input logic [N-1:0] eg,
                                input logic [N-1:0] ed, input logic [N-1:0] ee,
                                input logic ev, input logic [W-1:0] es);
        vec_t v;
        v.rst_n = r;  v.req = rq; v.sig2 = s2;
        v.gnt = eg;   v.done = ed; v.err = ee;
        v.valid = ev; v.sig1 = es;
        return v;
    endfunction

    // Drive inputs, clock once, compare the registered outputs 1 ns later.
    task automatic step(input logic r, input logic [N-1:0] rq, input logic s2,
                        input logic [N-1:0] eg, input logic [N-1:0] ed,
                        input logic [N-1:0] ee, input logic ev,
                        input logic [W-1:0] es, input string nm);
        logic [3*N+2+W-1:0] act, exp_v;
        rst_n = r;
        req   = rq;
        sig2  = s2;
        @(posedge clk);
        #1;
        act   = {gnt, done, err, sig1_valid, busy, sig1};
        exp_v = {eg, ed, ee, ev, ev, es};
        checks++;
        if (act === exp_v) passed++;
        else $display("FAIL %s: got gnt=%b done=%b err=%b v=%b busy=%b sig1=%h, want gnt=%b done=%b err=%b v=%b busy=%b sig1=%h",
                      nm, gnt, done, err, sig1_valid, busy, sig1, eg, ed, ee, ev, ev, es);
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        sig2     = 1'b0;
        req_data = {D3, D2, D1, D0};

        // reset, release, round robin with immediate ack, 3-cycle transfer
        tbl[0]  = mk(0, 4'b1111, 0, 4'b0000, 4'b0000, 4'b0000, 0, '0);
        tbl[1]  = mk(0, 4'b1111, 0, 4'b0000, 4'b0000, 4'b0000, 0, '0);
        tbl[2]  = mk(1, 4'b1111, 0, 4'b0001, 4'b0000, 4'b0000, 1, D0);
        tbl[3]  = mk(1, 4'b1111, 1, 4'b0000, 4'b0001, 4'b0000, 0, '0);
        tbl[4]  = mk(1, 4'b1111, 1, 4'b0010, 4'b0000, 4'b0000, 1, D1);
        tbl[5]  = mk(1, 4'b1111, 1, 4'b0000, 4'b0010, 4'b0000, 0, '0);
        tbl[6]  = mk(1, 4'b1111, 1, 4'b0100, 4'b0000, 4'b0000, 1, D2);
        tbl[7]  = mk(1, 4'b1111, 1, 4'b0000, 4'b0100, 4'b0000, 0, '0);
        tbl[8]  = mk(1, 4'b1111, 1, 4'b1000, 4'b0000, 4'b0000, 1, D3);
        tbl[9]  = mk(1, 4'b1111, 1, 4'b0000, 4'b1000, 4'b0000, 0, '0);
        tbl[10] = mk(1, 4'b1111, 1, 4'b0001, 4'b0000, 4'b0000, 1, D0);
        tbl[11] = mk(1, 4'b0000, 1, 4'b0000, 4'b0001, 4'b0000, 0, '0);
        tbl[12] = mk(1, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, '0);
        tbl[13] = mk(1, 4'b0100, 0, 4'b0100, 4'b0000, 4'b0000, 1, D2);
        tbl[14] = mk(1, 4'b0000, 0, 4'b0100, 4'b0000, 4'b0000, 1, D2);
        tbl[15] = mk(1, 4'b0000, 0, 4'b0100, 4'b0000, 4'b0000, 1, D2);
        tbl[16] = mk(1, 4'b0000, 1, 4'b0000, 4'b0100, 4'b0000, 0, '0);

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].rst_n, tbl[i].req, tbl[i].sig2, tbl[i].gnt,
                 tbl[i].done, tbl[i].err, tbl[i].valid, tbl[i].sig1,
                 $sformatf("vec%0d", i));
        end

        // timeout: valid exactly TO cycles, then err pulse
        step(1, 4'b0010, 0, 4'b0010, 4'b0000, 4'b0000, 1, D1, "to_start");
        for (int i = 1; i < TO; i++)
            step(1, 4'b0010, 0, 4'b0010, 4'b0000, 4'b0000, 1, D1,
                 $sformatf("to_hold%0d", i));
        step(1, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0010, 0, '0, "to_err");
        step(1, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, '0, "to_quiet");

        // ack in the last allowed cycle, req withdrawn mid-transfer
        step(1, 4'b0001, 0, 4'b0001, 4'b0000, 4'b0000, 1, D0, "late_start");
        for (int i = 1; i < TO; i++)
            step(1, (i < 5) ? 4'b0001 : 4'b0000, 0, 4'b0001, 4'b0000,
                 4'b0000, 1, D0, $sformatf("late_hold%0d", i));
        step(1, 4'b0000, 1, 4'b0000, 4'b0001, 4'b0000, 0, '0, "late_ack");

        // reset mid-transfer: silent abort, priority back to requester 0
        step(1, 4'b1100, 0, 4'b0100, 4'b0000, 4'b0000, 1, D2, "mid_start");
        step(0, 4'b1100, 1, 4'b0000, 4'b0000, 4'b0000, 0, '0, "mid_rst");
        step(1, 4'b1111, 0, 4'b0001, 4'b0000, 4'b0000, 1, D0, "mid_prio");
        step(1, 4'b0000, 1, 4'b0000, 4'b0001, 4'b0000, 0, '0, "mid_ack");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ifmp_bus_arbiter.md
Name: ifmp_bus_arbiter

Overview:
Round-robin arbiter and transfer sequencer that shares one master/slave interface bus (32-bit master-driven sig1, single-bit slave-driven sig2 acknowledge) among NUM_REQ requesters. It grants one requester at a time and drives that requester's word onto sig1 with a valid strobe. It then waits for the slave's sig2 acknowledge, or aborts on timeout. It sits between the requesting blocks and the slave side of the interface.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
BUS_WIDTH, 32, width of sig1 and of each requester data word
TIMEOUT, 16, max cycles sig1_valid may stay high without sig2 before abort (>=2)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
req  input  NUM_REQ  per-requester request level
req_data  input  NUM_REQ*BUS_WIDTH  packed data words, requester i at [i*BUS_WIDTH +: BUS_WIDTH]
gnt  output  NUM_REQ  one-hot grant, held for the whole transfer
done  output  NUM_REQ  one-cycle pulse on the winner's bit when the slave acknowledges
err  output  NUM_REQ  one-cycle pulse on the winner's bit on timeout abort
sig1  output  BUS_WIDTH  bus data to slave
sig1_valid  output  1  sig1 holds a valid transfer
sig2  input  1  slave acknowledge
busy  output  1  high in XFER state

Behaviour:
- Reset: one clock, synchronous, active-low. rst_n low at a rising edge sets state IDLE. gnt, done, err, sig1, sig1_valid and busy go to 0, timeout counter 0, and the round-robin pointer is set so that requester 0 has top priority. Reset mid-transfer aborts silently, with no done or err pulse.
- States: IDLE, XFER.
- IDLE: sig2 is ignored. If req != 0, pick the winner as the first set bit scanning upward from (last_winner+1) mod NUM_REQ. Next cycle: state XFER, gnt=onehot(winner), sig1=req_data[winner] (latched), sig1_valid=1, busy=1, counter=0, last_winner=winner.
- Latency: req sampled high in IDLE at cycle n -> gnt/sig1_valid high at n+1.
- XFER:
  - sig1 and gnt are held stable.
  - Changes on req or req_data are ignored; withdrawing req does not abort the transfer.
  - Counter increments each cycle sig2 is low.
- Acknowledge: sig2 high in XFER at cycle k -> at k+1 done[winner]=1, gnt=0, sig1_valid=0, sig1=0, busy=0, state IDLE. The earliest next grant is k+2; arbitration happens in the IDLE cycle, so there is always at least one idle cycle between transfers.
- Timeout: if sig2 is low in the cycle where counter == TIMEOUT-1, the next cycle gives err[winner]=1 and the same deassertion as done, then state IDLE. sig1_valid is therefore high for exactly TIMEOUT cycles on abort.
- sig2 high in the timeout cycle: acknowledge wins, done=1, err=0.
- done and err are never both high. Each is a single-cycle pulse and is zero outside the cycle after transfer end.
- Fairness: the pointer advances only on grant. A requester holding req continuously is served within NUM_REQ transfers.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with req=4'b1111 -> all outputs 0. Release with req=4'b1111 -> gnt=4'b0001 one cycle after release, sig1=req_data[0].
- Single transfer: req=4'b0100, data2=32'hDEADBEEF, slave acks 3 cycles after valid -> sig1_valid high 3 cycles, sig1=32'hDEADBEEF throughout, done=4'b0100 pulse, gnt cleared the same cycle.
- Round robin: req=4'b1111 held, slave acks immediately -> grant order 0,1,2,3,0. Each transfer is 1 valid cycle followed by 1 done/idle cycle.
- Timeout: TIMEOUT=16, req=4'b0010, sig2 never asserted -> sig1_valid high exactly 16 cycles, then err=4'b0010 pulse and done=0. A subsequent req=4'b0001 is granted normally.
- Ack on final cycle: sig2 asserted in the 16th valid cycle -> done pulse, err stays 0. Also check that req withdrawn mid-XFER keeps gnt/sig1 stable until the ack.
- Reset mid-transfer: rst_n=0 during XFER -> next cycle gnt=0, sig1_valid=0, no done/err. After release, requester 0 has top priority.
